softusb_rxfifo: RTL and testbench
=================================

Name: softusb_rxfifo

Overview:
- Packet buffer directly downstream of the SoftUSB serial receiver.
- Consumes the receiver's byte stream and framing strobes (rx_sync, rx_valid, rx_eop, error flags), all in the usb_clk domain.
- Stores each packet's bytes (PID through CRC) in a circular byte RAM and commits a per-packet status entry at EOP.
- Exposes committed packets to the SoftUSB microcontroller through a byte-read / packet-pop interface. Overflowed and empty packets are discarded and counted.

Parameters:
ADDR_W, 7, log2 of data RAM depth (128 bytes); also the width of pkt_len minus 1.
STAT_AW, 2, log2 of status FIFO depth (4 packets).

Ports:
usb_clk  in  1  clock, sole clock domain.
usb_rst_n  in  1  asynchronous active-low reset.
rx_data  in  8  received byte, valid with rx_valid.
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
rx_sync  in  1  one-cycle strobe: SYNC found, packet start.
rx_eop  in  1  one-cycle strobe: packet end (normal or bitstuff abort).
rx_error  in  1  bitstuff error; only meaningful with rx_eop.
rx_pid_error  in  1  PID check failed; sampled only during rx_eop.
rx_crc_error  in  1  CRC check failed; sampled only during rx_eop.
pkt_valid  out  1  status FIFO non-empty.
pkt_len  out  ADDR_W+1  byte count of head packet.
pkt_flags  out  3  head packet {crc_err, pid_err, stuff_err}.
rd_en  in  1  read next byte of head packet.
rd_data  out  8  byte read, registered.
rd_ack  out  1  rd_data updated this cycle.
pkt_pop  in  1  release head packet and its bytes.
drop_count  out  8  saturating count of discarded packets.
drop_clr  in  1  synchronous clear of drop_count.

Behaviour:
- Reset (async, usb_rst_n=0): all pointers 0, wstate=IDLE, pkt_valid=0, pkt_len=0, pkt_flags=0, rd_data=0, rd_ack=0, drop_count=0. RAM contents undefined. Reset may assert mid-packet; the partial packet vanishes.
- Pointers (all ADDR_W+1 bits, wrap modulo 2^(ADDR_W+1)):
  - wbase: commit point.
  - wptr: tentative write pointer.
  - rbase: start of head packet.
  - roff: read offset within head packet.
- Occupancy = wptr - rbase. RAM is full when occupancy = 2^ADDR_W. Space frees only on pkt_pop.
- Write state machine, states IDLE / RECV / DISCARD:
  - IDLE, rx_sync: go to RECV; wptr<=wbase, len<=0.
  - RECV, rx_valid, not full: RAM[wptr]<=rx_data; wptr+1; len+1.
  - RECV, rx_valid, full: go to DISCARD; wptr<=wbase.
  - RECV, rx_eop with len=0: discard, drop_count+1, go to IDLE.
  - RECV, rx_eop with status FIFO full (2^STAT_AW entries): discard, drop_count+1, wptr<=wbase, go to IDLE.
  - RECV, rx_eop otherwise: push {len, rx_crc_error, rx_pid_error, rx_error}; wbase<=wptr; go to IDLE. The push is visible as pkt_valid on the next cycle.
  - RECV, rx_sync without prior eop (receiver timeout restart): abandon the partial packet, wptr<=wbase, len<=0, stay in RECV. Not counted as a drop.
  - DISCARD, rx_eop: drop_count+1, go to IDLE. In DISCARD, rx_valid and rx_sync are ignored.
  - IDLE: rx_valid and rx_eop are ignored.
- Same-cycle rx_valid and rx_eop: the byte is written before the commit and is counted in len.
- Errored packets (crc/pid/stuff) are committed with their flags set; software decides what to do with them.
- Read side:
  - rd_en with pkt_valid and roff<pkt_len: rd_data<=RAM[rbase+roff] on the next edge; rd_ack=1 for that cycle; roff+1.
  - rd_en otherwise: ignored, rd_ack=0.
  - pkt_pop with pkt_valid: rbase<=rbase+pkt_len; roff<=0; status FIFO head advances. Unread bytes are skipped.
  - pkt_pop and rd_en in the same cycle: pop wins, no read. pkt_pop with pkt_valid=0 is ignored.
  - The read side only touches committed bytes, so there is no read/write hazard.
- Same-cycle pop and status push: both take effect; the FIFO count is unchanged.
- Same-cycle pop and full-check: fullness uses pre-pop rbase (conservative).
- drop_count saturates at 255. drop_clr has priority over a same-cycle increment.

Test Plan:
- 3-byte packet: sync, bytes C3 01 02, eop, no errors → pkt_valid=1, pkt_len=3, pkt_flags=0. Three rd_en give rd_data C3, 01, 02 with rd_ack. A 4th rd_en gives rd_ack=0. pkt_pop → pkt_valid=0.
- CRC error packet: 5 bytes, eop with rx_crc_error=1 → committed, pkt_flags=3'b100. Sync then immediate eop → no entry, drop_count=1.
- Overflow: ADDR_W=7, a 130-byte packet → DISCARD at byte 129, no entry, drop_count+1. A following 10-byte packet commits with pkt_len=10.
- Status full: 5 two-byte packets with no pops → 4 entries, drop_count=1. Pop the head with the 5th eop in the same cycle → 5th committed, 4 entries remain.
- Restart and wrap: sync, 4 bytes, sync, 2 bytes, eop → pkt_len=2 with the later bytes. Run many 50-byte packets with pops across pointer wrap → data intact.
- Reset and counter: usb_rst_n low mid-RECV → all outputs 0 immediately; the next packet is received normally. 300 drops → drop_count=255. drop_clr → 0.

Source files
------------

// File: rtl/softusb_rxfifo.sv
`default_nettype none
// ============================================================================
//  Module   : softusb_rxfifo
//  Purpose  : Packet buffer behind the SoftUSB serial receiver. Received bytes
//             (PID through CRC) are stored in a circular byte RAM. One status
//             entry per packet is committed at EOP. The microcontroller reads
//             committed packets byte by byte and releases them with a pop.
//             Overflowed and empty packets are discarded and counted.
//  Ports    : usb_clk, usb_rst_n         clock / async active-low reset
//             rx_data, rx_valid          received byte stream
//             rx_sync, rx_eop            packet start / end strobes
//             rx_error, rx_pid_error,
//             rx_crc_error               error flags, sampled with rx_eop
//             pkt_valid, pkt_len,
//             pkt_flags                  head packet status
//             rd_en, rd_data, rd_ack     byte read of the head packet
//             pkt_pop                    release the head packet
//             drop_count, drop_clr       saturating discard counter
//  Revision : 1.0  initial release
// ============================================================================
module softusb_rxfifo #(
  parameter int ADDR_W  = 7,   // log2 of data RAM depth
  parameter int STAT_AW = 2    // log2 of status FIFO depth
) (
  input  logic              usb_clk,
  input  logic              usb_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sync,
  input  logic              rx_eop,
  input  logic              rx_error,
  input  logic              rx_pid_error,
  input  logic              rx_crc_error,
  output logic              pkt_valid,
  output logic [ADDR_W:0]   pkt_len,
  output logic [2:0]        pkt_flags,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_ack,
  input  logic              pkt_pop,
  output logic [7:0]        drop_count,
  input  logic              drop_clr
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SDEPTH = 1 << STAT_AW;

  // Occupancy value meaning "RAM full" and status count meaning "FIFO full".
  localparam logic [ADDR_W:0]  c_full_occ   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [STAT_AW:0] c_stat_depth = {1'b1, {STAT_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } wstate_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wstate_t             wstate_q;
  logic [ADDR_W:0]     wbase_q;     // commit point
  logic [ADDR_W:0]     wptr_q;      // tentative write pointer
  logic [ADDR_W:0]     len_q;       // bytes of the packet in progress
  logic [ADDR_W:0]     rbase_q;     // start of head packet
  logic [ADDR_W:0]     roff_q;      // read offset within head packet

  logic [7:0]          mem_q [DEPTH];

  logic [ADDR_W:0]     stat_len_q   [SDEPTH];
  logic [2:0]          stat_flags_q [SDEPTH];
  logic [STAT_AW-1:0]  stat_wr_q;
  logic [STAT_AW-1:0]  stat_rd_q;
  logic [STAT_AW:0]    stat_cnt_q;

  logic [7:0]          rd_data_q;
  logic                rd_ack_q;
  logic [7:0]          drop_q;

  // --------------------------------------------------------------------------
  // Write-side decode
  // --------------------------------------------------------------------------
  logic                w_full;
  logic                w_in_recv;
  logic                w_byte_wr;
  logic                w_byte_ovf;
  logic [ADDR_W:0]     w_len_eff;
  logic [ADDR_W:0]     w_wptr_next;
  logic                w_stat_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_rd_ok;
  logic [ADDR_W-1:0]   w_raddr;

  // Fullness deliberately uses the registered rbase, so a same-cycle pop
  // does not free space until the following cycle.
  assign w_full      = ((wptr_q - rbase_q) == c_full_occ);

  // A sync while receiving restarts the packet and masks every other strobe.
  assign w_in_recv   = (wstate_q == RECV) && !rx_sync;
  assign w_byte_wr   = w_in_recv && rx_valid && !w_full;
  assign w_byte_ovf  = w_in_recv && rx_valid &&  w_full;

  // A byte arriving together with EOP is part of the committed length.
  assign w_len_eff   = len_q  + {{ADDR_W{1'b0}}, w_byte_wr};
  assign w_wptr_next = wptr_q + {{ADDR_W{1'b0}}, w_byte_wr};

  assign w_stat_full = (stat_cnt_q == c_stat_depth);
  assign w_pop       = pkt_pop && pkt_valid;

  // A full status FIFO still accepts the push when the head is popped in
  // the same cycle.
  assign w_push      = w_in_recv && rx_eop && !w_byte_ovf &&
                       (w_len_eff != '0) && (!w_stat_full || w_pop);
  assign w_drop      = (w_in_recv && rx_eop && !w_push) ||
                       ((wstate_q == DISCARD) && rx_eop);

  // --------------------------------------------------------------------------
  // Write state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      wstate_q <= IDLE;
      wbase_q  <= '0;
      wptr_q   <= '0;
      len_q    <= '0;
    end else begin
      case (wstate_q)
        IDLE: begin
          if (rx_sync) begin
            wstate_q <= RECV;
            wptr_q   <= wbase_q;
            len_q    <= '0;
          end
        end
        RECV: begin
          if (rx_sync) begin
            // Receiver restarted without EOP: abandon the partial packet.
            wptr_q <= wbase_q;
            len_q  <= '0;
          end else if (w_byte_ovf) begin
            wptr_q   <= wbase_q;
            wstate_q <= rx_eop ? IDLE : DISCARD;
          end else begin
            if (w_byte_wr) begin
              wptr_q <= w_wptr_next;
              len_q  <= w_len_eff;
            end
            if (rx_eop) begin
              wstate_q <= IDLE;
              if (w_push) begin
                wbase_q <= w_wptr_next;
              end else begin
                wptr_q  <= wbase_q;
              end
            end
          end
        end
        DISCARD: begin
          if (rx_eop) begin
            wstate_q <= IDLE;
          end
        end
        default: wstate_q <= IDLE;
      endcase
    end
  end

  // Data RAM: contents are not reset.
  always_ff @(posedge usb_clk) begin
    if (w_byte_wr) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Status FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge usb_clk) begin
    if (w_push) begin
      stat_len_q[stat_wr_q]   <= w_len_eff;
      stat_flags_q[stat_wr_q] <= {rx_crc_error, rx_pid_error, rx_error};
    end
  end

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      stat_wr_q  <= '0;
      stat_rd_q  <= '0;
      stat_cnt_q <= '0;
    end else begin
      if (w_push) begin
        stat_wr_q <= stat_wr_q + 1'b1;
      end
      if (w_pop) begin
        stat_rd_q <= stat_rd_q + 1'b1;
      end
      stat_cnt_q <= stat_cnt_q + {{STAT_AW{1'b0}}, w_push}
                               - {{STAT_AW{1'b0}}, w_pop};
    end
  end

  assign pkt_valid = (stat_cnt_q != '0);
  assign pkt_len   = pkt_valid ? stat_len_q[stat_rd_q]   : '0;
  assign pkt_flags = pkt_valid ? stat_flags_q[stat_rd_q] : '0;

  // --------------------------------------------------------------------------
  // Read side: only committed bytes are addressed, so no write hazard exists.
  // --------------------------------------------------------------------------
  assign w_rd_ok = rd_en && pkt_valid && !pkt_pop && (roff_q < pkt_len);
  assign w_raddr = rbase_q[ADDR_W-1:0] + roff_q[ADDR_W-1:0];

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      rbase_q   <= '0;
      roff_q    <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      rd_ack_q <= w_rd_ok;
      if (w_rd_ok) begin
        rd_data_q <= mem_q[w_raddr];
      end
      if (w_pop) begin
        // Unread bytes of the head packet are skipped.
        rbase_q <= rbase_q + pkt_len;
        roff_q  <= '0;
      end else if (w_rd_ok) begin
        roff_q  <= roff_q + 1'b1;
      end
    end
  end

  assign rd_data = rd_data_q;
  assign rd_ack  = rd_ack_q;

  // --------------------------------------------------------------------------
  // Drop counter: clear beats increment, saturates at 255.
  // --------------------------------------------------------------------------
  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      drop_q <= '0;
    end else if (drop_clr) begin
      drop_q <= '0;
    end else if (w_drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_softusb_rxfifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softusb_rxfifo
//  Purpose  : Self-checking bench for softusb_rxfifo. Committed packets are
//             modelled as a flat byte queue plus length/flag queues; drops
//             are modelled as a saturating integer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_softusb_rxfifo;

  localparam int ADDR_W  = 7;
  localparam int STAT_AW = 2;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int SDEPTH  = 1 << STAT_AW;

  logic              usb_clk = 1'b0;
  logic              usb_rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_sync = 1'b0;
  logic              rx_eop = 1'b0;
  logic              rx_error = 1'b0;
  logic              rx_pid_error = 1'b0;
  logic              rx_crc_error = 1'b0;
  logic              pkt_valid;
  logic [ADDR_W:0]   pkt_len;
  logic [2:0]        pkt_flags;
  logic              rd_en = 1'b0;
  logic [7:0]        rd_data;
  logic              rd_ack;
  logic              pkt_pop = 1'b0;
  logic [7:0]        drop_count;
  logic              drop_clr = 1'b0;

  softusb_rxfifo #(.ADDR_W(ADDR_W), .STAT_AW(STAT_AW)) dut (
    .usb_clk      (usb_clk),
    .usb_rst_n    (usb_rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_sync      (rx_sync),
    .rx_eop       (rx_eop),
    .rx_error     (rx_error),
    .rx_pid_error (rx_pid_error),
    .rx_crc_error (rx_crc_error),
    .pkt_valid    (pkt_valid),
    .pkt_len      (pkt_len),
    .pkt_flags    (pkt_flags),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_ack       (rd_ack),
    .pkt_pop      (pkt_pop),
    .drop_count   (drop_count),
    .drop_clr     (drop_clr)
  );

  always #5 usb_clk = ~usb_clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] model_data [$];
  int         model_len  [$];
  logic [2:0] model_flags[$];
  int         model_drop = 0;
  logic [7:0] tx_bytes   [$];

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic model_pop_head();
    for (int i = 0; i < model_len[0]; i++) void'(model_data.pop_front());
    void'(model_len.pop_front());
    void'(model_flags.pop_front());
  endtask

  task automatic model_clear();
    model_data.delete();
    model_len.delete();
    model_flags.delete();
    model_drop = 0;
  endtask

  // Send one packet made of tx_bytes and update the model with its outcome.
  task automatic send_pkt(input logic [2:0] fl, input bit eop_with_last,
                          input bit pop_at_eop, input bit gaps);
    int  n         = tx_bytes.size();
    int  committed = model_data.size();
    bit  had_head  = (model_len.size() != 0);
    bit  commit;
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_data  = tx_bytes[i];
      rx_valid = 1'b1;
      if (eop_with_last && i == n - 1) begin
        rx_eop = 1'b1;
        {rx_crc_error, rx_pid_error, rx_error} = fl;
        pkt_pop = pop_at_eop;
      end
      tick();
      rx_valid = 1'b0; rx_eop = 1'b0; pkt_pop = 1'b0;
      {rx_crc_error, rx_pid_error, rx_error} = 3'b000;
      if (gaps && $urandom_range(0, 1) == 1) tick();
    end
    if (!(eop_with_last && n > 0)) begin
      rx_eop = 1'b1;
      {rx_crc_error, rx_pid_error, rx_error} = fl;
      pkt_pop = pop_at_eop;
      tick();
      rx_eop = 1'b0; pkt_pop = 1'b0;
      {rx_crc_error, rx_pid_error, rx_error} = 3'b000;
    end
    // Outcome from the rules: space and status slots are judged before the pop.
    commit = (n != 0) && (committed + n <= DEPTH) &&
             ((model_len.size() < SDEPTH) || (pop_at_eop && had_head));
    if (pop_at_eop && had_head) model_pop_head();
    if (commit) begin
      foreach (tx_bytes[i]) model_data.push_back(tx_bytes[i]);
      model_len.push_back(n);
      model_flags.push_back(fl);
    end else if (model_drop < 255) begin
      model_drop++;
    end
  endtask

  task automatic fill_random(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endtask

  task automatic verify_head(input string tag);
    int         exp_len   = (model_len.size() != 0) ? model_len[0] : 0;
    logic [2:0] exp_flags = (model_len.size() != 0) ? model_flags[0] : 3'b000;
    logic       exp_valid = (model_len.size() != 0);
    checks++;
    if (pkt_valid !== exp_valid) begin
      errors++;
      $display("FAIL %s pkt_valid: got %b expected %b", tag, pkt_valid, exp_valid);
    end
    checks++;
    if (pkt_len !== (ADDR_W+1)'(exp_len)) begin
      errors++;
      $display("FAIL %s pkt_len: got %0d expected %0d", tag, pkt_len, exp_len);
    end
    checks++;
    if (pkt_flags !== exp_flags) begin
      errors++;
      $display("FAIL %s pkt_flags: got %b expected %b", tag, pkt_flags, exp_flags);
    end
    checks++;
    if (drop_count !== 8'(model_drop)) begin
      errors++;
      $display("FAIL %s drop_count: got %0d expected %0d", tag, drop_count, model_drop);
    end
  endtask

  // Read every byte of the head packet, try one read too many, then pop.
  task automatic read_and_pop(input string tag);
    int n;
    verify_head(tag);
    if (model_len.size() == 0) return;
    n = model_len[0];
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      checks++;
      if (rd_ack !== 1'b1 || rd_data !== model_data[i]) begin
        errors++;
        $display("FAIL %s byte %0d: got ack=%b data=%h expected ack=1 data=%h",
                 tag, i, rd_ack, rd_data, model_data[i]);
      end
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++;
    if (rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s read past end: got ack=%b expected ack=0", tag, rd_ack);
    end
    pkt_pop = 1'b1; tick(); pkt_pop = 1'b0;
    model_pop_head();
  endtask

  task automatic drain_all(input string tag);
    while (model_len.size() != 0) read_and_pop(tag);
    verify_head({tag, "_empty"});
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    usb_rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pkt_valid, pkt_len, pkt_flags, rd_data, rd_ack, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b len=%0d flags=%b data=%h ack=%b drop=%0d expected all 0",
               pkt_valid, pkt_len, pkt_flags, rd_data, rd_ack, drop_count);
    end
    usb_rst_n = 1'b1;
    tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++;
    if (rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_when_empty: got ack=%b expected 0", rd_ack);
    end
  endtask

  task automatic test_basic();
    tx_bytes = '{8'hC3, 8'h01, 8'h02};
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_len !== 8'd3 || pkt_flags !== 3'b000) begin
      errors++;
      $display("FAIL basic_status: got valid=%b len=%0d flags=%b expected 1/3/000",
               pkt_valid, pkt_len, pkt_flags);
    end
    read_and_pop("basic");
    verify_head("basic_after_pop");
  endtask

  task automatic test_errors();
    fill_random(5);
    send_pkt(3'b100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pkt_flags !== 3'b100) begin
      errors++;
      $display("FAIL crc_flags: got %b expected 100", pkt_flags);
    end
    read_and_pop("crc");
    tx_bytes.delete();
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (drop_count !== 8'd1 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pkt: got drop=%0d valid=%b expected 1/0", drop_count, pkt_valid);
    end
    fill_random(4); send_pkt(3'b010, 1'b1, 1'b0, 1'b1);
    fill_random(3); send_pkt(3'b001, 1'b0, 1'b0, 1'b1);
    drain_all("flags");
  endtask

  task automatic test_overflow();
    fill_random(130);
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    verify_head("overflow");
    fill_random(10);
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pkt_len !== 8'd10) begin
      errors++;
      $display("FAIL after_overflow_len: got %0d expected 10", pkt_len);
    end
    drain_all("after_overflow");
    fill_random(DEPTH);
    send_pkt(3'b000, 1'b1, 1'b0, 1'b0);
    drain_all("exact_full");
  endtask

  task automatic test_status_full();
    for (int k = 0; k < SDEPTH + 1; k++) begin
      fill_random(2);
      send_pkt(3'(k), 1'b0, 1'b0, 1'b0);
    end
    verify_head("stat_full");
    fill_random(2);
    send_pkt(3'b011, 1'b0, 1'b1, 1'b0);
    drain_all("stat_full_pop");
  endtask

  task automatic test_restart();
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'hE0 + 8'(i); rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    end
    tx_bytes = '{8'h5A, 8'hA5};
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pkt_len !== 8'd2) begin
      errors++;
      $display("FAIL restart_len: got %0d expected 2", pkt_len);
    end
    drain_all("restart");
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 24; k++) begin
      fill_random((k < 8) ? 50 : $urandom_range(1, 50));
      send_pkt(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (model_len.size() >= 2 || $urandom_range(0, 2) == 0) read_and_pop("wrap");
    end
    drain_all("wrap_end");
  endtask

  task automatic test_reset_mid();
    tx_bytes = '{8'hA5, 8'h5A, 8'h3C};
    send_pkt(3'b001, 1'b0, 1'b0, 1'b0);
    tx_bytes.delete();
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    rx_data = 8'h77; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    #2 usb_rst_n = 1'b0;
    #1;
    checks++;
    if ({pkt_valid, pkt_len, pkt_flags, rd_data, rd_ack, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b len=%0d flags=%b data=%h ack=%b drop=%0d expected all 0",
               pkt_valid, pkt_len, pkt_flags, rd_data, rd_ack, drop_count);
    end
    model_clear();
    #2 usb_rst_n = 1'b1;
    tick();
    fill_random(4);
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    drain_all("after_reset");
  endtask

  task automatic test_drop_counter();
    tx_bytes.delete();
    for (int k = 0; k < 300; k++) send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (drop_count !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d expected 255", drop_count);
    end
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    model_drop = 0;
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL drop_clr: got %0d expected 0", drop_count);
    end
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    rx_eop = 1'b1; drop_clr = 1'b1; tick(); rx_eop = 1'b0; drop_clr = 1'b0;
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL drop_clr_priority: got %0d expected 0", drop_count);
    end
    send_pkt(3'b000, 1'b0, 1'b0, 1'b0);
    verify_head("drop_after_clr");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_overflow();
    test_status_full();
    test_restart();
    test_wrap();
    test_reset_mid();
    test_drop_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
